arb_grant_router: RTL and testbench
===================================

# arb_grant_router

Downstream companion to the four-client round-robin arbiter. It consumes the arbiter's registered one-hot grant vector and moves one data word per cycle from the currently granted client into a small first-word-fall-through FIFO. The FIFO output is a valid/ready channel, and each word is tagged with the index of its source client. Each capture is acknowledged to its client with a same-cycle ACK strobe. Illegal (non-one-hot) grant patterns are flagged.

## Interface
- DATA_W, 8, width of each client data word
- FIFO_DEPTH, 4, entries in output FIFO; power of two, >= 2
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count (derived, not overridden)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- GNT  in  4  one-hot grant from the arbiter; 4'b0000 = idle
- VALID  in  4  per-client "word present" qualifier
- DIN  in  4*DATA_W  client i data at DIN[i*DATA_W +: DATA_W]
- ACK  out  4  combinational strobe; ACK[i]=1 in the cycle client i's word is written to the FIFO
- dout  out  DATA_W  FIFO head data; 0 when empty
- dout_id  out  2  source client index of head word; 0 when empty
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts head when dout_valid & dout_ready
- fifo_count  out  CNT_W  current occupancy, 0..FIFO_DEPTH
- gnt_err  out  1  sticky; set when GNT has more than one bit set

## Operation
- Grant decode: `one_hot = (GNT != 0) && ((GNT & (GNT-1)) == 0)`. The index i is the position of the set bit.
- Pop: `pop = dout_valid & dout_ready`.
- Push: `push = one_hot & VALID[i] & ((fifo_count < FIFO_DEPTH) | pop)`. When full, a push is accepted only together with a simultaneous pop.
- On a push, entry {i, DIN[i]} is written at the write pointer, and ACK[i]=1 for that cycle only. All other ACK bits are 0.
- ACK protocol for clients: a client holds VALID/DIN stable until it sees ACK. In the cycle after ACK it presents its next word or deasserts VALID. Every ACK cycle consumes exactly one word.
- Grant idle (GNT=0) or the granted client's VALID=0: no push, ACK=0.
- Non-one-hot GNT: no push, ACK=0, and gnt_err is set on the next edge. gnt_err holds until rst.
- Pointers: wr_ptr and rd_ptr are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Push advances wr_ptr and pop advances rd_ptr.
- Count update:
  - push only: fifo_count+1
  - pop only: fifo_count-1
  - push and pop together: count unchanged
- FIFO output is first-word-fall-through: dout/dout_id come combinationally from the entry at rd_ptr, masked to 0 when empty.
- Ordering: words leave in exact capture order regardless of client.

## Timing
- Reset (rst=1 at an edge):
  - wr_ptr=rd_ptr=0, fifo_count=0, gnt_err=0
  - so dout_valid=0, dout=0, dout_id=0
  - ACK is forced to 0 whenever rst=1
  - memory contents are don't-care
- rst asserted mid-operation: all queued words are discarded on that edge, and no ACK is issued during the rst cycle.
- Capture latency: a push at edge N makes the word visible on dout with dout_valid=1 after edge N when the FIFO was empty. A same-cycle bypass from DIN to dout is not permitted.
- Throughput: one push and one pop per cycle sustained. A full FIFO with dout_ready held high accepts a push every cycle.
- Grant changes: a new GNT is honoured in the same cycle it arrives. No dead cycle is inserted.
- Empty with dout_ready=1: no pop, count stays 0, and there is no underflow.
- Full without pop: push is blocked, ACK=0, and the client keeps waiting with VALID held.

## Test plan
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then GNT=0.
  - Required: dout_valid=0, fifo_count=0, ACK=0, gnt_err=0, dout=0.
- Single capture:
  - Stimulus: GNT=4'b0100, VALID=4'b0100, DIN[2]=8'hA5, dout_ready=0.
  - Required: ACK=4'b0100 in that cycle. Next cycle dout=8'hA5, dout_id=2, fifo_count=1.
- Fill and back-pressure (FIFO_DEPTH=4):
  - Stimulus: GNT cycles 0001→0010→0100→1000→0001 with all VALID=1, dout_ready=0.
  - Required: four ACKs, fifo_count=4, fifth cycle ACK=0.
  - Then dout_ready=1: ids pop as 0,1,2,3, and the pending client-0 word is ACKed in the first pop cycle (push+pop, count stays 4).
- Full-rate streaming:
  - Stimulus: GNT=4'b0001, VALID[0]=1, DIN[0] incrementing 1..20, dout_ready=1.
  - Required: ACK every cycle, dout sequence 1..20 with one-cycle lag, fifo_count constant at 1.
- Illegal grant:
  - Stimulus: GNT=4'b0011, VALID=4'b0011.
  - Required: ACK=0, no count change, gnt_err=1 next cycle and held until rst.
- Reset mid-stream:
  - Stimulus: 3 words queued, rst pulsed for 1 cycle with GNT/VALID active.
  - Required: ACK=0 during rst, after the edge fifo_count=0 and dout_valid=0, and capture resumes on the next cycle.

Source files
------------

// File: rtl/arb_grant_router_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : arb_grant_router_if
//  Brief    : Grant/data/ACK client bus plus the valid/ready FIFO output channel
//  Revision : 1.0  initial release
// ============================================================================
interface arb_grant_router_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]          GNT;
  logic [3:0]          VALID;
  logic [4*DATA_W-1:0] DIN;
  logic [3:0]          ACK;
  logic [DATA_W-1:0]   dout;
  logic [1:0]          dout_id;
  logic                dout_valid;
  logic                dout_ready;
  logic [c_CNT_W-1:0]  fifo_count;
  logic                gnt_err;

  modport master (
    output GNT, VALID, DIN, dout_ready,
    input  ACK, dout, dout_id, dout_valid, fifo_count, gnt_err
  );

  modport slave (
    input  GNT, VALID, DIN, dout_ready,
    output ACK, dout, dout_id, dout_valid, fifo_count, gnt_err
  );
endinterface
`default_nettype wire

// File: rtl/arb_grant_router.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : arb_grant_router
//  Brief    : Moves the granted client's word into a tagged FWFT FIFO with ACK
//  Revision : 1.0  initial release
// ============================================================================
module arb_grant_router #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  arb_grant_router_if.slave  bus
);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [DATA_W-1:0]  r_mem_data [FIFO_DEPTH];
  logic [1:0]         r_mem_id   [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_gnt_err;

  logic               w_one_hot;
  logic               w_multi;
  logic [1:0]         w_idx;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic [DATA_W-1:0]  w_din_sel;

  always_comb begin
    w_one_hot = (bus.GNT != 4'd0) && ((bus.GNT & (bus.GNT - 4'd1)) == 4'd0);
    w_multi   = (bus.GNT != 4'd0) && !w_one_hot;
    case (bus.GNT)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
    w_din_sel = bus.DIN[w_idx*DATA_W +: DATA_W];
    w_empty   = (r_count == '0);
    w_full    = (r_count == c_CNT_W'(FIFO_DEPTH));
    w_pop     = !w_empty && bus.dout_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    w_push    = !rst && w_one_hot && bus.VALID[w_idx] && (!w_full || w_pop);
  end

  assign bus.ACK        = w_push ? (4'b0001 << w_idx) : 4'b0000;
  assign bus.dout       = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign bus.dout_id    = w_empty ? 2'd0 : r_mem_id[r_rd_ptr];
  assign bus.dout_valid = !w_empty;
  assign bus.fifo_count = r_count;
  assign bus.gnt_err    = r_gnt_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_din_sel;
      r_mem_id[r_wr_ptr]   <= w_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_gnt_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_multi) r_gnt_err <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_arb_grant_router.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_arb_grant_router
//  Brief    : Queue-model bench with directed scenarios and random client traffic
//  Revision : 1.0  initial release
// ============================================================================
module tb_arb_grant_router;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  arb_grant_router_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  arb_grant_router #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: queue of {id, data} in capture order; occupancy is its size.
  logic [9:0]    mq [$];
  logic          exp_err = 1'b0;
  logic [3:0]    exp_ack;
  logic          exp_pop;
  logic          exp_valid;
  logic [DW-1:0] exp_dout;
  logic [1:0]    exp_id;
  int            exp_count;
  logic          exp_multi;
  logic          chk_en = 1'b0;

  logic [DW-1:0] cur_w [4];
  logic [3:0]    cur_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_eval();
    int n;
    int idx;
    idx       = 0;
    exp_valid = (mq.size() != 0);
    exp_dout  = '0;
    exp_id    = 2'd0;
    if (exp_valid) begin
      exp_dout = mq[0][7:0];
      exp_id   = mq[0][9:8];
    end
    exp_count = mq.size();
    exp_pop   = exp_valid && bus.dout_ready;
    exp_ack   = 4'b0000;
    n         = $countones(bus.GNT);
    exp_multi = (n > 1);
    if (!rst && n == 1) begin
      for (int i = 0; i < 4; i++) if (bus.GNT[i]) idx = i;
      if (bus.VALID[idx] && (mq.size() < DEPTH || exp_pop)) exp_ack[idx] = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("ack",        32'(bus.ACK),        32'(exp_ack));
      chk("dout_valid", 32'(bus.dout_valid), 32'(exp_valid));
      chk("dout",       32'(bus.dout),       32'(exp_dout));
      chk("dout_id",    32'(bus.dout_id),    32'(exp_id));
      chk("fifo_count", 32'(bus.fifo_count), 32'(exp_count));
      chk("gnt_err",    32'(bus.gnt_err),    32'(exp_err));
    end
  end

  task automatic drive(input logic [3:0] g, input logic [3:0] v, input logic [4*DW-1:0] d,
                       input logic rdy, input logic r, input logic en);
    @(negedge clk);
    bus.GNT        = g;
    bus.VALID      = v;
    bus.DIN        = d;
    bus.dout_ready = rdy;
    rst            = r;
    model_eval();
    chk_en = en;
    #3;
  endtask

  task automatic commit();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_err = 1'b0;
    end else begin
      if (exp_pop) void'(mq.pop_front());
      for (int i = 0; i < 4; i++)
        if (exp_ack[i]) mq.push_back({2'(i), bus.DIN[i*DW +: DW]});
      if (exp_multi) exp_err = 1'b1;
    end
  endtask

  logic [4*DW-1:0] din_f;
  logic [3:0]      g;
  int              r;

  initial begin
    bus.GNT = '0; bus.VALID = '0; bus.DIN = '0; bus.dout_ready = 1'b0; rst = 1'b1;

    // Reset then idle
    drive(4'h0, 4'h0, '0, 1'b0, 1'b1, 1'b0); commit();
    drive(4'h0, 4'h0, '0, 1'b0, 1'b1, 1'b1); commit();
    drive(4'h0, 4'h0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_ack",   32'(bus.ACK),        32'd0);
    chk("rst_err",   32'(bus.gnt_err),    32'd0);
    chk("rst_dout",  32'(bus.dout),       32'd0);
    commit();

    // Single capture
    drive(4'b0100, 4'b0100, 32'h00A5_0000, 1'b0, 1'b0, 1'b1);
    chk("single_ack", 32'(bus.ACK), 32'b0100);
    commit();
    drive(4'h0, 4'h0, '0, 1'b0, 1'b0, 1'b1);
    chk("single_dout",  32'(bus.dout),       32'hA5);
    chk("single_id",    32'(bus.dout_id),    32'd2);
    chk("single_count", 32'(bus.fifo_count), 32'd1);
    commit();
    drive(4'h0, 4'h0, '0, 1'b1, 1'b0, 1'b1); commit();
    drive(4'h0, 4'h0, '0, 1'b1, 1'b0, 1'b1);
    chk("empty_ready_count", 32'(bus.fifo_count), 32'd0);
    commit();

    // Fill and back-pressure
    din_f = 32'h1312_1110;
    for (int i = 0; i < 4; i++) begin
      drive(4'(1 << i), 4'hF, din_f, 1'b0, 1'b0, 1'b1);
      chk("fill_ack", 32'(bus.ACK), 32'(1 << i));
      commit();
    end
    drive(4'b0001, 4'hF, din_f, 1'b0, 1'b0, 1'b1);
    chk("full_ack",   32'(bus.ACK),        32'd0);
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    commit();
    drive(4'b0001, 4'hF, din_f, 1'b1, 1'b0, 1'b1);
    chk("fullpop_ack",   32'(bus.ACK),        32'b0001);
    chk("fullpop_count", 32'(bus.fifo_count), 32'd4);
    chk("fullpop_id",    32'(bus.dout_id),    32'd0);
    commit();
    for (int j = 0; j < 4; j++) begin
      drive(4'h0, 4'h0, din_f, 1'b1, 1'b0, 1'b1);
      chk("drain_id", 32'(bus.dout_id), 32'((j + 1) % 4));
      commit();
    end

    // Full-rate streaming
    for (int k = 1; k <= 20; k++) begin
      drive(4'b0001, 4'b0001, {24'h0, 8'(k)}, 1'b1, 1'b0, 1'b1);
      chk("stream_ack", 32'(bus.ACK), 32'd1);
      if (k > 1) begin
        chk("stream_dout",  32'(bus.dout),       32'(k - 1));
        chk("stream_count", 32'(bus.fifo_count), 32'd1);
      end
      commit();
    end
    drive(4'h0, 4'h0, '0, 1'b1, 1'b0, 1'b1); commit();

    // Illegal grant
    drive(4'b0011, 4'b0011, din_f, 1'b0, 1'b0, 1'b1);
    chk("illegal_ack",   32'(bus.ACK),        32'd0);
    chk("illegal_count", 32'(bus.fifo_count), 32'd0);
    commit();
    for (int j = 0; j < 3; j++) begin
      drive(4'h0, 4'h0, '0, 1'b0, 1'b0, 1'b1);
      chk("illegal_err", 32'(bus.gnt_err), 32'd1);
      commit();
    end

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(4'(1 << i), 4'hF, din_f, 1'b0, 1'b0, 1'b1); commit();
    end
    drive(4'b0001, 4'b0001, din_f, 1'b0, 1'b1, 1'b1);
    chk("midrst_ack", 32'(bus.ACK), 32'd0);
    commit();
    drive(4'b0001, 4'b0001, din_f, 1'b0, 1'b0, 1'b1);
    chk("midrst_count", 32'(bus.fifo_count), 32'd0);
    chk("midrst_valid", 32'(bus.dout_valid), 32'd0);
    chk("midrst_ack2",  32'(bus.ACK),        32'd1);
    chk("midrst_err",   32'(bus.gnt_err),    32'd0);
    commit();

    // Random client traffic obeying the hold-until-ACK protocol
    cur_v = 4'h0;
    for (int i = 0; i < 4; i++) cur_w[i] = 8'($urandom);
    for (int c = 0; c < 2000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       g = 4'h0;
      else if (r < 10) g = 4'($urandom_range(0, 15));
      else             g = 4'b0001 << $urandom_range(0, 3);
      drive(g, cur_v, {cur_w[3], cur_w[2], cur_w[1], cur_w[0]},
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 249) == 0), 1'b1);
      commit();
      for (int i = 0; i < 4; i++) begin
        if (exp_ack[i]) begin
          cur_w[i] = 8'($urandom);
          cur_v[i] = ($urandom_range(0, 3) != 0);
        end else if (!cur_v[i] && $urandom_range(0, 1) == 1) begin
          cur_w[i] = 8'($urandom);
          cur_v[i] = 1'b1;
        end
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
